cass_in_slicer: RTL and testbench

Cassette-input slicer that sits directly downstream of the audio codec interface's ADC deserializer. It consumes one 16-bit two's-complement sample per LRCK frame and converts it into a clean digital cassette-in level using a hysteresis comparator with a consecutive-sample debounce. It also measures the period between rising edges, in samples, for the tape loader logic.

---
 rtl/cass_in_slicer_pkg.sv | 11 +
 rtl/cass_in_slicer_if.sv | 20 ++
 rtl/cass_dc_tracker.sv | 41 ++++
 rtl/cass_in_slicer.sv | 120 ++++++++++++
 tb/tb_cass_in_slicer.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/cass_in_slicer_pkg.sv
// cass_in_slicer_pkg: shared audio definitions for the cassette-in slicer.
//   slicerState_t  : hysteresis/debounce FSM states
//   DATA_WIDTH_DEF : default ADC sample width
//   HYST_HI_DEF    : default rising threshold (sample must be strictly above)
//   HYST_LO_DEF    : default falling threshold (sample must be strictly below)
package cass_in_slicer_pkg;
   typedef enum logic [1:0] {LOW, RISE_PEND, HIGH, FALL_PEND} slicerState_t;
   localparam int DATA_WIDTH_DEF = 16;
   localparam logic signed [15:0] HYST_HI_DEF = 16'sh1000;
   localparam logic signed [15:0] HYST_LO_DEF = -16'sh1000;
endpackage

// File: rtl/cass_in_slicer_if.sv
// cass_in_slicer_if: sample input and slicer result bundle.
//   sample/sampleVld : signed ADC sample and its one-BCLK valid pulse (master -> slave)
//   cassBit          : debounced cassette level
//   edgePulse        : one-cycle pulse on any cassBit change
//   period/periodVld : samples between the last two rising edges, with update pulse
//   ovf              : sticky period-counter saturation flag
interface cass_in_slicer_if #(
   parameter int DATA_WIDTH = cass_in_slicer_pkg::DATA_WIDTH_DEF,
   parameter int PERIOD_W = 12
);
   logic signed [DATA_WIDTH-1:0] sample;
   logic sampleVld;
   logic cassBit;
   logic edgePulse;
   logic [PERIOD_W-1:0] period;
   logic periodVld;
   logic ovf;
   modport master (output sample, sampleVld, input cassBit, edgePulse, period, periodVld, ovf);
   modport slave (input sample, sampleVld, output cassBit, edgePulse, period, periodVld, ovf);
endinterface

// File: rtl/cass_dc_tracker.sv
// cass_dc_tracker: DC estimator and saturating DC-removal subtractor.
//   BCLK, iRST_N : clock, asynchronous active-low reset
//   sample       : signed input sample
//   sampleVld    : sample qualifier
//   diff         : registered (sample - dc), saturated to DATA_WIDTH, updated per valid sample
// Only instantiated when CASS_DC_TRACK_EN is defined.
module cass_dc_tracker #(
   parameter int DATA_WIDTH = 16
) (
   input  logic BCLK,
   input  logic iRST_N,
   input  logic signed [DATA_WIDTH-1:0] sample,
   input  logic sampleVld,
   output logic signed [DATA_WIDTH-1:0] diff
);
   // estimate carries 8 fractional bits so the >>>8 leak does not stall on small errors
   localparam int ACC_W = DATA_WIDTH + 8;
   localparam logic signed [DATA_WIDTH-1:0] S_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
   localparam logic signed [DATA_WIDTH-1:0] S_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};
   logic signed [ACC_W-1:0] dcAcc, dcNxt;
   logic signed [ACC_W:0] err;
   logic signed [DATA_WIDTH-1:0] dcInt, diffSat;
   logic signed [DATA_WIDTH:0] diffWide;
   always_comb begin
      err = {sample[DATA_WIDTH-1], sample, 8'h00} - {dcAcc[ACC_W-1], dcAcc};
      dcNxt = dcAcc + ACC_W'(err >>> 8);
      dcInt = dcNxt[ACC_W-1:8];
      diffWide = {sample[DATA_WIDTH-1], sample} - {dcInt[DATA_WIDTH-1], dcInt};
      diffSat = (diffWide[DATA_WIDTH] != diffWide[DATA_WIDTH-1])
              ? (diffWide[DATA_WIDTH] ? S_MIN : S_MAX)
              : diffWide[DATA_WIDTH-1:0];
   end
   always_ff @(posedge BCLK or negedge iRST_N)
      if (!iRST_N) begin
         dcAcc <= '0;
         diff <= '0;
      end else if (sampleVld) begin
         dcAcc <= dcNxt;
         diff <= diffSat;
      end
endmodule

// File: rtl/cass_in_slicer.sv
// cass_in_slicer: hysteresis comparator with consecutive-sample debounce and
// rising-edge period measurement for the cassette-in path.
//   BCLK   : bit clock, all logic on posedge
//   iRST_N : asynchronous active-low reset
//   bus    : cass_in_slicer_if.slave (sample/sampleVld in; cassBit, edgePulse,
//            period, periodVld, ovf out)
// Optional: define CASS_DC_TRACK_EN to compare against a DC-removed sample
// (one valid sample of extra comparator delay).
module cass_in_slicer
   import cass_in_slicer_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter logic signed [DATA_WIDTH-1:0] HYST_HI = HYST_HI_DEF,
   parameter logic signed [DATA_WIDTH-1:0] HYST_LO = HYST_LO_DEF,
   parameter int DEB_N = 2,
   parameter int PERIOD_W = 12
) (
   input logic BCLK,
   input logic iRST_N,
   cass_in_slicer_if.slave bus
);
   localparam logic [3:0] DEB_TGT = 4'(DEB_N);
   localparam logic [PERIOD_W-1:0] PCNT_MAX = '1;
   slicerState_t state, stateNxt;
   logic [3:0] deb, debNxt, debInc;
   logic [PERIOD_W-1:0] pcnt, pcntNxt, pcntSat, period, periodNxt;
   logic signed [DATA_WIDTH-1:0] cmpVal;
   logic aboveHi, belowLo, debDone, rise, fall, edgeQ, periodVld, ovf, ovfNxt;

`ifdef CASS_DC_TRACK_EN
   cass_dc_tracker #(.DATA_WIDTH(DATA_WIDTH)) uDcTracker (
      .BCLK(BCLK),
      .iRST_N(iRST_N),
      .sample(bus.sample),
      .sampleVld(bus.sampleVld),
      .diff(cmpVal)
   );
`else
   assign cmpVal = bus.sample;
`endif

   assign aboveHi = cmpVal > HYST_HI;
   assign belowLo = cmpVal < HYST_LO;
   assign debInc = deb + 4'd1;
   assign debDone = debInc == DEB_TGT;
   assign pcntSat = pcnt + PERIOD_W'(pcnt != PCNT_MAX);

   always_ff @(posedge BCLK or negedge iRST_N)
      if (!iRST_N) begin
         state <= LOW;
         deb <= '0;
         pcnt <= '0;
         period <= '0;
         periodVld <= 1'b0;
         edgeQ <= 1'b0;
         ovf <= 1'b0;
      end else begin
         state <= stateNxt;
         deb <= debNxt;
         pcnt <= pcntNxt;
         period <= periodNxt;
         periodVld <= rise;
         edgeQ <= rise | fall;
         ovf <= ovfNxt;
      end

   // dead-band samples are non-qualifying, so pending states fall back
   always_comb begin
      stateNxt = state;
      debNxt = deb;
      rise = 1'b0;
      fall = 1'b0;
      if (bus.sampleVld)
         case (state)
            LOW:
               if (aboveHi) begin
                  stateNxt = (DEB_N == 1) ? HIGH : RISE_PEND;
                  debNxt = (DEB_N == 1) ? 4'd0 : 4'd1;
                  rise = DEB_N == 1;
               end
            RISE_PEND: begin
               stateNxt = !aboveHi ? LOW : (debDone ? HIGH : RISE_PEND);
               debNxt = (!aboveHi || debDone) ? 4'd0 : debInc;
               rise = aboveHi && debDone;
            end
            HIGH:
               if (belowLo) begin
                  stateNxt = (DEB_N == 1) ? LOW : FALL_PEND;
                  debNxt = (DEB_N == 1) ? 4'd0 : 4'd1;
                  fall = DEB_N == 1;
               end
            FALL_PEND: begin
               stateNxt = !belowLo ? HIGH : (debDone ? LOW : FALL_PEND);
               debNxt = (!belowLo || debDone) ? 4'd0 : debInc;
               fall = belowLo && debDone;
            end
         endcase
   end

   // the rising sample itself counts toward the period, hence pcnt+1
   always_comb begin
      pcntNxt = pcnt;
      periodNxt = period;
      ovfNxt = ovf;
      if (rise) begin
         periodNxt = pcntSat;
         pcntNxt = '0;
         ovfNxt = &pcnt;
      end else if (bus.sampleVld) begin
         pcntNxt = pcntSat;
         ovfNxt = ovf | (&pcntSat);
      end
   end

   assign bus.cassBit = (state == HIGH) || (state == FALL_PEND);
   assign bus.edgePulse = edgeQ;
   assign bus.period = period;
   assign bus.periodVld = periodVld;
   assign bus.ovf = ovf;
endmodule

// File: tb/tb_cass_in_slicer.sv
// tb_cass_in_slicer: scoreboard bench for cass_in_slicer (default build, DEB_N=2, PERIOD_W=12).
module tb_cass_in_slicer;
   logic BCLK = 1'b0;
   logic iRST_N = 1'b0;
   always #5 BCLK = ~BCLK;

   cass_in_slicer_if #(.DATA_WIDTH(16), .PERIOD_W(12)) bus ();

   cass_in_slicer #(
      .DATA_WIDTH(16),
      .HYST_HI(16'sh1000),
      .HYST_LO(-16'sh1000),
      .DEB_N(2),
      .PERIOD_W(12)
   ) dut (
      .BCLK(BCLK),
      .iRST_N(iRST_N),
      .bus(bus)
   );

   typedef struct packed {
      logic cb;
      logic ed;
      logic pv;
      logic ov;
      logic [11:0] per;
   } exp_t;

   exp_t sb[$];
   int errors = 0;
   int checks = 0;
   int nSample = 0;
   bit mBit;
   bit mOvf;
   int mRun, mCnt, mPer;

   task automatic modelReset();
      mBit = 0;
      mOvf = 0;
      mRun = 0;
      mCnt = 0;
      mPer = 0;
   endtask

   // drive one sample at a negedge; expected outputs go to the scoreboard and
   // are compared at the following negedge
   task automatic sendSample(input int v);
      exp_t e, g;
      bit rise;
      bus.sample = 16'(v);
      bus.sampleVld = 1'b1;
      rise = 0;
      e = '0;
      if (mBit ? (v < -4096) : (v > 4096)) mRun++;
      else mRun = 0;
      if (mRun == 2) begin
         mBit = !mBit;
         mRun = 0;
         e.ed = 1;
         rise = mBit;
      end
      if (rise) begin
         mPer = (mCnt == 4095) ? 4095 : mCnt + 1;
         mOvf = (mCnt == 4095);
         mCnt = 0;
         e.pv = 1;
      end else begin
         if (mCnt < 4095) mCnt++;
         if (mCnt == 4095) mOvf = 1;
      end
      e.cb = mBit;
      e.ov = mOvf;
      e.per = 12'(mPer);
      sb.push_back(e);
      @(negedge BCLK);
      bus.sampleVld = 1'b0;
      e = sb.pop_front();
      g = {bus.cassBit, bus.edgePulse, bus.periodVld, bus.ovf, bus.period};
      checks++;
      if (g !== e) begin
         errors++;
         $display("FAIL sample#%0d (%0d): got bit=%b edge=%b pvld=%b ovf=%b period=%0d, expected bit=%b edge=%b pvld=%b ovf=%b period=%0d",
                  nSample, v, g.cb, g.ed, g.pv, g.ov, g.per, e.cb, e.ed, e.pv, e.ov, e.per);
      end
      nSample++;
   endtask

   task automatic checkBit(input string name, input logic expBit);
      checks++;
      if (bus.cassBit !== expBit) begin
         errors++;
         $display("FAIL %s: cassBit=%b expected %b", name, bus.cassBit, expBit);
      end
   endtask

   task automatic checkZero(input string name);
      checks++;
      if ({bus.cassBit, bus.edgePulse, bus.periodVld, bus.ovf, bus.period} !== 16'd0) begin
         errors++;
         $display("FAIL %s: outputs bit=%b edge=%b pvld=%b ovf=%b period=%0d expected all 0",
                  name, bus.cassBit, bus.edgePulse, bus.periodVld, bus.ovf, bus.period);
      end
   endtask

   task automatic test_reset();
      bus.sample = 16'sh7000;
      bus.sampleVld = 1'b0;
      iRST_N = 1'b0;
      modelReset();
      repeat (4) begin
         @(negedge BCLK);
         bus.sampleVld = 1'b1;
         checkZero("reset_hold");
      end
      @(negedge BCLK);
      bus.sampleVld = 1'b0;
      iRST_N = 1'b1;
      @(negedge BCLK);
      checkZero("reset_release");
      sendSample(16'sh7000);
      sendSample(16'sh7000);
      checks++;
      if (bus.period !== 12'd2 || bus.cassBit !== 1'b1 || bus.periodVld !== 1'b1) begin
         errors++;
         $display("FAIL first_rise: period=%0d bit=%b pvld=%b expected 2/1/1", bus.period, bus.cassBit, bus.periodVld);
      end
   endtask

   task automatic test_glitch();
      sendSample(-16'sh2000);
      sendSample(-16'sh2000);
      checkBit("glitch_setup", 1'b0);
      for (int r = 0; r < 3; r++) begin
         sendSample(-16'sh2000);
         sendSample(16'sh2000);
      end
      sendSample(-16'sh2000);
      checkBit("glitch", 1'b0);
   endtask

   task automatic test_dead_band();
      sendSample(16'sh2000);
      sendSample(16'sh2000);
      repeat (6) sendSample(16'sh0800);
      checkBit("dead_band_hold", 1'b1);
      sendSample(-16'sh1001);
      sendSample(-16'sh1001);
      checkBit("below_lo", 1'b0);
      sendSample(16'sh2000);
      sendSample(16'sh2000);
      sendSample(-16'sh1000);
      sendSample(-16'sh1000);
      checkBit("at_lo", 1'b1);
      sendSample(-16'sh2000);
      sendSample(-16'sh2000);
      sendSample(16'sh1000);
      sendSample(16'sh1000);
      checkBit("at_hi", 1'b0);
      sendSample(16'sh1001);
      sendSample(16'sh1001);
      checkBit("above_hi", 1'b1);
   endtask

   task automatic test_gaps();
      sendSample(-16'sh2000);
      sendSample(-16'sh2000);
      bus.sample = 16'sh7000;
      repeat (5) @(negedge BCLK);
      checks++;
      if (bus.cassBit !== 1'b0 || bus.edgePulse !== 1'b0) begin
         errors++;
         $display("FAIL idle_hold: bit=%b edge=%b expected 0/0", bus.cassBit, bus.edgePulse);
      end
      sendSample(16'sh7000);
      repeat (3) @(negedge BCLK);
      checkBit("gap_pending", 1'b0);
      sendSample(16'sh7000);
      checkBit("gap_rise", 1'b1);
   endtask

   task automatic test_period();
      repeat (12) sendSample(-16'sh2000);
      for (int c = 0; c < 5; c++) begin
         for (int i = 0; i < 12; i++) begin
            sendSample(16'sh3000);
            if (i == 1 && c > 0) begin
               checks++;
               if (bus.periodVld !== 1'b1 || bus.period !== 12'd24 || bus.ovf !== 1'b0) begin
                  errors++;
                  $display("FAIL period_24: pvld=%b period=%0d ovf=%b expected 1/24/0", bus.periodVld, bus.period, bus.ovf);
               end
            end
         end
         repeat (12) sendSample(-16'sh3000);
      end
   endtask

   task automatic test_overflow();
      repeat (5000) sendSample(-16'sh2000);
      checks++;
      if (bus.ovf !== 1'b1) begin
         errors++;
         $display("FAIL ovf_set: ovf=%b expected 1", bus.ovf);
      end
      sendSample(16'sh2000);
      sendSample(16'sh2000);
      checks++;
      if (bus.period !== 12'd4095 || bus.ovf !== 1'b1) begin
         errors++;
         $display("FAIL ovf_rise: period=%0d ovf=%b expected 4095/1", bus.period, bus.ovf);
      end
      repeat (10) sendSample(16'sh2000);
      repeat (12) sendSample(-16'sh2000);
      sendSample(16'sh2000);
      sendSample(16'sh2000);
      checks++;
      if (bus.period !== 12'd24 || bus.ovf !== 1'b0) begin
         errors++;
         $display("FAIL ovf_clear: period=%0d ovf=%b expected 24/0", bus.period, bus.ovf);
      end
   endtask

   task automatic test_async_reset();
      repeat (3) sendSample(-16'sh2000);
      sendSample(16'sh2000);
      #2 iRST_N = 1'b0;
      #1;
      checks++;
      if (dut.state !== cass_in_slicer_pkg::LOW) begin
         errors++;
         $display("FAIL async_rise_pend: state=%0d expected LOW", dut.state);
      end
      checkZero("async_rise_pend_out");
      @(negedge BCLK);
      iRST_N = 1'b1;
      modelReset();
      sendSample(16'sh2000);
      checkBit("after_reset_first", 1'b0);
      sendSample(16'sh2000);
      checkBit("after_reset_second", 1'b1);
      sendSample(-16'sh2000);
      checkBit("fall_pend", 1'b1);
      #2 iRST_N = 1'b0;
      #1;
      checkZero("async_fall_pend");
      @(negedge BCLK);
      iRST_N = 1'b1;
      modelReset();
      sendSample(16'sh2000);
      sendSample(16'sh2000);
      checks++;
      if (bus.period !== 12'd2) begin
         errors++;
         $display("FAIL async_period: period=%0d expected 2", bus.period);
      end
   endtask

   initial begin
      bus.sample = '0;
      bus.sampleVld = 1'b0;
      test_reset();
      test_glitch();
      test_dead_band();
      test_gaps();
      test_period();
      test_overflow();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
